hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard unit for the 5-stage pipeline that adds a register scoreboard for a multi-cycle, non-pipelined floating-point execution unit. It keeps the existing duties: EX-stage operand forwarding, load-use stall, and control-hazard flush. It also tracks in-flight FP destination registers, stalls Decode on RAW, WAW and structural hazards against the FP unit, and times FP completion. It sits beside the pipeline registers and drives the stall and flush inputs of the PC, IF/ID and ID/EX registers, plus the FP unit's done/write-back handshake.

## Interface
- NREG, 32, architectural register count; register index 0 is hard-wired zero.
- AW, $clog2(NREG), register index width.
- FP_LAT, 4, FP unit latency in cycles, from issue to write-back; legal range 2..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed.
- Rs1D, Rs2D, RdD  in  AW  Decode-stage register indices.
- RegWriteD  in  1  Decode instruction writes a register.
- FpOpD  in  1  Decode instruction is an FP-unit op.
- Rs1E, Rs2E, RdE  in  AW  Execute-stage register indices.
- ResultSrcE  in  2  01 = load in Execute.
- FpOpE  in  1  Execute instruction is an FP op; this is the issue request.
- PCSrcE  in  1  branch taken / jump in Execute.
- RdM, RegWriteM  in  AW, 1  Memory-stage destination.
- RdW, RegWriteW  in  AW, 1  Writeback-stage destination.
- ForwardAE, ForwardBE  out  2  00 = register file, 01 = ResultW, 10 = ALUResultM.
- StallF, StallD, FlushD, FlushE  out  1  pipeline control.
- FpBusy  out  1  FP unit occupied.
- FpDoneW  out  1  one-cycle pulse; FP result valid and written through the second regfile port this cycle.
- FpRdW  out  AW  destination of the completing FP op; valid when FpDoneW=1.
- Pending  out  NREG  scoreboard bits, for debug and verification.

## Operation
- **Forwarding** (per operand, combinational):
  - Select 10 if RegWriteM & RdM==RsxE & RsxE!=0.
  - Otherwise select 01 if RegWriteW & RdW==RsxE & RsxE!=0.
  - Otherwise select 00. The M stage has priority over W.
- **Hazard terms** (combinational). In each term below, "Rsx" means Rs1D or Rs2D, and only a nonzero index counts.
  - lwStall: ResultSrcE==01, and RdE matches a nonzero Rsx.
  - fpIssueStall: FpOpE, and RdE matches a nonzero Rsx. This covers the case where the scoreboard bit is not yet set.
  - rawStall: Pending[Rs1D] or Pending[Rs2D].
  - wawStall: (RegWriteD | FpOpD), and Pending[RdD].
  - structStall: FpOpD, and (FpBusy | FpOpE).
  - stall = OR of all five terms.
- **Outputs:**
  - StallF = StallD = stall & ~PCSrcE. Redirect wins, because the stalled Decode instruction is being flushed anyway.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | stall.
- **FP unit state**, with a down-counter cnt of width $clog2(FP_LAT+1):
  - Issue: FpOpE=1 in cycle n. At the end of n, cnt <= FP_LAT, and Pending[RdE] <= 1 if RdE!=0. The destination is latched into FpRdW.
  - FpBusy = (cnt!=0).
  - FpDoneW = (cnt==1).
  - Each cycle with cnt!=0, cnt decrements.
  - When cnt==1, Pending[FpRdW] clears at the end of that cycle.
  - An FP op with RdE==0 still occupies the unit and pulses FpDoneW, but sets no pending bit.
- **Invariants:**
  - FpOpE=1 never coincides with FpBusy=1, because structStall guarantees it. Verification asserts this.
  - Set and clear of the same Pending bit never occur in the same cycle.
  - Pending[0] is always 0.
  - At most one Pending bit is set.

## Timing
- Forwarding, stalls and flushes are combinational from the inputs and current state, with zero latency.
- FP issue in cycle n gives:
  - FpBusy high in cycles n+1 .. n+FP_LAT.
  - FpDoneW high in cycle n+FP_LAT.
  - Pending bit high in cycles n+1 .. n+FP_LAT.
  - A dependent Decode instruction leaves Decode in cycle n+FP_LAT+1 or later.
- The register file writes at the edge and reads combinationally, so no FP-result forwarding path is required.
- Reset values: cnt=0, Pending=0, FpRdW=0, FpBusy=0, FpDoneW=0. Control outputs follow from those values and the inputs.
- Reset mid-operation abandons the in-flight FP op: no FpDoneW pulse, and the scoreboard is cleared.
- PCSrcE together with stall gives StallF=StallD=0, FlushD=1, FlushE=1.

## Structure
- Shared package hazard_pkg holds:
  - FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RESSRC_LOAD=2'b01;
  - a typedef for register index width.
- One natural sub-module: fp_scoreboard, containing cnt, Pending, FpRdW, FpBusy and FpDoneW.
- The top level holds forwarding and the stall/flush combinational logic.

## Test plan
- **Forwarding priority:** RdM=RdW=5, both RegWrite=1, Rs1E=5 gives ForwardAE=10. Dropping RegWriteM gives 01. Rs1E=0 gives 00.
- **Load-use:** ResultSrcE=01, RdE=7, Rs2D=7 gives StallF=StallD=1 and FlushE=1 for one cycle; with RdE=0 there is no stall.
- **FP RAW (FP_LAT=4):**
  - Issue an FP op to x9 in cycle 0.
  - Hold Rs1D=9 in Decode.
  - Expected: stall in cycles 0..4; FpDoneW=1 and FpRdW=9 in cycle 4; Pending[9]=0 and stall=0 in cycle 5.
- **Structural and WAW:**
  - With FpBusy=1 and FpOpD=1, expect stall until the cycle after FpDoneW.
  - With RegWriteD=1 and RdD equal to the pending register, expect stall.
- **Branch overrides stall:** lwStall true and PCSrcE=1 gives StallF=StallD=0 and FlushD=FlushE=1.
- **Reset mid-op:** issue an FP op to x3, assert reset in cycle 2. Expected: Pending=0, FpBusy=0, and no FpDoneW pulse afterwards; a new FP issue then completes normally after FP_LAT cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings and types for the hazard unit and its FP scoreboard.
package hazard_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESSRC_LOAD = 2'b01;

    localparam int NREG_DEF = 32;
    localparam int AW_DEF   = $clog2(NREG_DEF);

    typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/hazard_scoreboard_fp_scoreboard.sv
// Occupancy counter and in-flight destination tracking for the non-pipelined FP unit.
module fp_scoreboard #(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int FP_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    output logic            busy,
    output logic            done,
    output logic [AW-1:0]   done_rd,
    output logic [NREG-1:0] pending
);

    localparam int CW = $clog2(FP_LAT + 1);

    logic [CW-1:0] cnt;

    assign busy = (cnt != '0);
    assign done = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            pending <= '0;
            done_rd <= '0;
        end else begin
            if (issue) begin
                cnt     <= CW'(FP_LAT);
                done_rd <= issue_rd;
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end
            if (done)
                pending[done_rd] <= 1'b0;
            // x0 never becomes pending, so reads of x0 never stall
            if (issue && issue_rd != '0)
                pending[issue_rd] <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: EX forwarding, load-use / FP RAW-WAW-structural stalls and branch flush.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int FP_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   Rs1D,
    input  logic [AW-1:0]   Rs2D,
    input  logic [AW-1:0]   RdD,
    input  logic            RegWriteD,
    input  logic            FpOpD,
    input  logic [AW-1:0]   Rs1E,
    input  logic [AW-1:0]   Rs2E,
    input  logic [AW-1:0]   RdE,
    input  logic [1:0]      ResultSrcE,
    input  logic            FpOpE,
    input  logic            PCSrcE,
    input  logic [AW-1:0]   RdM,
    input  logic            RegWriteM,
    input  logic [AW-1:0]   RdW,
    input  logic            RegWriteW,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FpBusy,
    output logic            FpDoneW,
    output logic [AW-1:0]   FpRdW,
    output logic [NREG-1:0] Pending
);

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs,
                                           input logic [AW-1:0] rdm, input logic wm,
                                           input logic [AW-1:0] rdw, input logic ww);
        if (wm && rdm == rs && rs != '0)      return FWD_M;
        else if (ww && rdw == rs && rs != '0) return FWD_W;
        else                                  return FWD_RF;
    endfunction

    logic rd_e_hit, lw_stall, fp_issue_stall, raw_stall, waw_stall, struct_stall, stall;

    fp_scoreboard #(.NREG(NREG), .AW(AW), .FP_LAT(FP_LAT)) u_fp (
        .clk      (clk),
        .reset    (reset),
        .issue    (FpOpE),
        .issue_rd (RdE),
        .busy     (FpBusy),
        .done     (FpDoneW),
        .done_rd  (FpRdW),
        .pending  (Pending)
    );

    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Covers the issue cycle itself, before the pending bit exists
    assign rd_e_hit = (Rs1D != '0 && RdE == Rs1D) || (Rs2D != '0 && RdE == Rs2D);

    assign lw_stall       = (ResultSrcE == RESSRC_LOAD) && rd_e_hit;
    assign fp_issue_stall = FpOpE && rd_e_hit;
    assign raw_stall      = Pending[Rs1D] || Pending[Rs2D];
    assign waw_stall      = (RegWriteD || FpOpD) && Pending[RdD];
    assign struct_stall   = FpOpD && (FpBusy || FpOpE);
    assign stall = lw_stall || fp_issue_stall || raw_stall || waw_stall || struct_stall;

    // A taken redirect flushes Decode anyway, so it must not also freeze it
    assign StallF = stall && !PCSrcE;
    assign StallD = stall && !PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = PCSrcE || stall;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: per-cycle expected outputs go into a queue, a negedge monitor checks them.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    reg_idx_t Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic RegWriteD, FpOpD, FpOpE, PCSrcE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, FlushD, FlushE, FpBusy, FpDoneW;
    reg_idx_t FpRdW;
    logic [31:0] Pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       nm;
        logic [1:0]  fa, fb;
        logic        stall, fd, fe, busy, done, rdchk;
        logic [4:0]  rd;
        logic [31:0] pend;
    } exp_t;

    exp_t q[$];

    hazard_scoreboard #(.NREG(32), .FP_LAT(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD), .FpOpD(FpOpD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE(ResultSrcE), .FpOpE(FpOpE),
        .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .FpBusy(FpBusy), .FpDoneW(FpDoneW),
        .FpRdW(FpRdW), .Pending(Pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, fld, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, "ForwardAE", 32'(ForwardAE), 32'(e.fa));
            chk(e.nm, "ForwardBE", 32'(ForwardBE), 32'(e.fb));
            chk(e.nm, "StallF", 32'(StallF), 32'(e.stall));
            chk(e.nm, "StallD", 32'(StallD), 32'(e.stall));
            chk(e.nm, "FlushD", 32'(FlushD), 32'(e.fd));
            chk(e.nm, "FlushE", 32'(FlushE), 32'(e.fe));
            chk(e.nm, "FpBusy", 32'(FpBusy), 32'(e.busy));
            chk(e.nm, "FpDoneW", 32'(FpDoneW), 32'(e.done));
            chk(e.nm, "Pending", Pending, e.pend);
            if (e.done || e.rdchk) chk(e.nm, "FpRdW", 32'(FpRdW), 32'(e.rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        {Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {RegWriteD, FpOpD, FpOpE, PCSrcE, RegWriteM, RegWriteW} = '0;
        ResultSrcE = 2'b00;
    endtask

    task automatic expect_out(input string nm, input logic [1:0] fa, input logic [1:0] fb,
                              input logic stall, input logic fd, input logic fe,
                              input logic busy, input logic done, input logic [4:0] rd,
                              input logic [31:0] pend, input logic rdchk = 1'b0);
        exp_t e;
        e.nm = nm; e.fa = fa; e.fb = fb; e.stall = stall; e.fd = fd; e.fe = fe;
        e.busy = busy; e.done = done; e.rd = rd; e.pend = pend; e.rdchk = rdchk;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        clr();
        tick(); tick();
        expect_out("reset", 2'b00, 2'b00, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1'b1);
        tick();
        reset = 1'b0;

        // forwarding priority
        RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        expect_out("fwd_m_over_w", 2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); RegWriteM = 0;
        expect_out("fwd_w", 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); RdM = 5; RegWriteM = 1; RdW = 6; RegWriteW = 1; Rs1E = 0; Rs2E = 6;
        expect_out("fwd_x0_and_w", 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); RdM = 3; RegWriteM = 1; RdW = 3; Rs1E = 3; Rs2E = 4;
        expect_out("fwd_m_only", 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        // load-use
        tick(); clr(); ResultSrcE = RESSRC_LOAD; RdE = 7; Rs2D = 7;
        expect_out("lw_rs2", 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 32'h0);
        tick(); clr(); ResultSrcE = RESSRC_LOAD; RdE = 7; Rs1D = 7;
        expect_out("lw_rs1", 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 32'h0);
        tick(); clr(); ResultSrcE = RESSRC_LOAD; RdE = 0; Rs2D = 7;
        expect_out("lw_rde0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); ResultSrcE = RESSRC_LOAD; RdE = 0; Rs1D = 0;
        expect_out("lw_x0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); ResultSrcE = 2'b10; RdE = 7; Rs2D = 7;
        expect_out("not_load", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        // branch overrides stall
        tick(); clr(); ResultSrcE = RESSRC_LOAD; RdE = 7; Rs1D = 7; PCSrcE = 1;
        expect_out("branch_lw", 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 32'h0);
        tick(); clr(); PCSrcE = 1;
        expect_out("branch_only", 2'b00, 2'b00, 0, 1, 1, 0, 0, 0, 32'h0);

        // FP RAW on x9
        tick(); clr(); FpOpE = 1; RdE = 9; Rs1D = 9;
        expect_out("raw_c0", 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 32'h0);
        tick(); clr(); Rs1D = 9;
        expect_out("raw_c1", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h200);
        tick(); expect_out("raw_c2", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h200);
        tick(); expect_out("raw_c3", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h200);
        tick(); expect_out("raw_c4", 2'b00, 2'b00, 1, 0, 1, 1, 1, 5'd9, 32'h200);
        tick(); expect_out("raw_c5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        // structural: FP op waiting in Decode behind x12
        tick(); clr(); FpOpE = 1; RdE = 12; FpOpD = 1; RdD = 13;
        expect_out("st_c0", 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 32'h0);
        tick(); clr(); FpOpD = 1; RdD = 13;
        expect_out("st_c1", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h1000);
        tick(); expect_out("st_c2", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h1000);
        tick(); expect_out("st_c3", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h1000);
        tick(); expect_out("st_c4", 2'b00, 2'b00, 1, 0, 1, 1, 1, 5'd12, 32'h1000);
        tick(); expect_out("st_c5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        // WAW on x20, then RAW through Rs2D
        tick(); clr(); FpOpE = 1; RdE = 20;
        expect_out("waw_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); RegWriteD = 1; RdD = 20;
        expect_out("waw_c1", 2'b00, 2'b00, 1, 0, 1, 1, 0, 0, 32'h100000);
        tick(); clr(); RegWriteD = 1; RdD = 21;
        expect_out("waw_other", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h100000);
        tick(); clr(); RdD = 20;
        expect_out("waw_nowrite", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h100000);
        tick(); clr(); Rs2D = 20;
        expect_out("waw_raw_c4", 2'b00, 2'b00, 1, 0, 1, 1, 1, 5'd20, 32'h100000);
        tick(); expect_out("waw_c5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        // FP op to x0: occupies the unit, no pending bit
        tick(); clr(); FpOpE = 1; RdE = 0;
        expect_out("x0_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); expect_out("x0_c1", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h0);
        tick(); tick();
        tick(); expect_out("x0_c4", 2'b00, 2'b00, 0, 0, 0, 1, 1, 5'd0, 32'h0);
        tick(); expect_out("x0_c5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        // reset mid-op abandons the x3 op
        tick(); clr(); FpOpE = 1; RdE = 3;
        expect_out("rst_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); expect_out("rst_c1", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h8);
        tick(); reset = 1;
        expect_out("rst_c2", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h8);
        tick(); reset = 0;
        expect_out("rst_c3", 2'b00, 2'b00, 0, 0, 0, 0, 0, 5'd0, 32'h0, 1'b1);
        tick(); expect_out("rst_c4", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); expect_out("rst_c5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); FpOpE = 1; RdE = 4;
        expect_out("re_c0", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(); clr(); expect_out("re_c1", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h10);
        tick(); expect_out("re_c2", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h10);
        tick(); expect_out("re_c3", 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, 32'h10);
        tick(); expect_out("re_c4", 2'b00, 2'b00, 0, 0, 0, 1, 1, 5'd4, 32'h10);
        tick(); expect_out("re_c5", 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0);

        tick(); tick();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
